// File: rtl/jump_sequencer.sv
// ---------------------------------------------------------------------------
// jump_sequencer
//
// Multicycle jump/link sequencer for a MIPS-style multicycle datapath. The
// main control FSM hands any jump-class instruction to this block. The block
// decodes J/JAL/JR/JALR, latches the target, issues the link-register write
// when one is needed, issues the PC load, and then reports done. Illegal
// opcodes and misaligned register targets end in a fault.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   start         request from the main control FSM (sampled only in IDLE)
//   instruction   instruction word, latched when start is accepted
//   pc            address of the current instruction, latched with start
//   rs_data       register-file read of instruction[25:21], valid in DECODE
//   busy          high in every state except IDLE
//   done          one-cycle completion pulse (normal or fault)
//   fault         high when the operation faulted; held until next start
//   fault_code    01 illegal opcode/funct, 10 misaligned target, else 00
//   link_write    register-file write enable pulse
//   link_addr     register-file write address (held between pulses)
//   link_data     register-file write data (held between pulses)
//   pc_write      PC load-enable pulse
//   pc_next       jump target (held between pulses)
//   current_state IDLE=0, DECODE=1, LINK=2, JUMP=3, FAULT=4
// ---------------------------------------------------------------------------
module jump_sequencer #(
    parameter int DATA_W      = 32,
    parameter int LINK_OFFSET = 4,
    parameter int LINK_REG    = 31,
    parameter int JALR_EN     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] rs_data,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic              link_write,
    output logic [4:0]        link_addr,
    output logic [DATA_W-1:0] link_data,
    output logic              pc_write,
    output logic [DATA_W-1:0] pc_next,
    output logic [2:0]        current_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        LINK   = 3'd2,
        JUMP   = 3'd3,
        FAULT  = 3'd4
    } state_t;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    localparam logic [1:0] CODE_ILLEGAL    = 2'b01;
    localparam logic [1:0] CODE_MISALIGNED = 2'b10;

    localparam logic [DATA_W-1:0] LINK_INC  = DATA_W'(LINK_OFFSET);
    localparam logic [4:0]        LINK_ADDR = 5'(LINK_REG);

    state_t            state;
    logic [31:0]       instr_q;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] target_q;

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        rd;
    logic [DATA_W-1:0] jump_target;
    logic              dec_fault;
    logic [1:0]        dec_code;
    logic              dec_link;
    logic [4:0]        dec_laddr;
    logic [DATA_W-1:0] dec_target;

    assign current_state = state;

    // Classification of the latched instruction; only consumed in DECODE,
    // which is the one cycle where rs_data is guaranteed valid.
    always_comb begin
        opcode      = instr_q[31:26];
        funct       = instr_q[5:0];
        rd          = instr_q[15:11];
        jump_target = {pc_q[DATA_W-1:28], instr_q[25:0], 2'b00};

        dec_fault  = 1'b0;
        dec_code   = 2'b00;
        dec_link   = 1'b0;
        dec_laddr  = LINK_ADDR;
        dec_target = jump_target;

        case (opcode)
            OP_J: begin
                dec_link = 1'b0;
            end
            OP_JAL: begin
                dec_link = 1'b1;
            end
            OP_SPECIAL: begin
                dec_target = rs_data;
                if (funct == FN_JR) begin
                    if (rs_data[1:0] != 2'b00) begin
                        dec_fault = 1'b1;
                        dec_code  = CODE_MISALIGNED;
                    end
                end else if (funct == FN_JALR && JALR_EN != 0) begin
                    if (rs_data[1:0] != 2'b00) begin
                        dec_fault = 1'b1;
                        dec_code  = CODE_MISALIGNED;
                    end else begin
                        // rd==0 would be a write to the hardwired zero
                        // register, so the link cycle is skipped entirely.
                        dec_link  = (rd != 5'd0);
                        dec_laddr = rd;
                    end
                end else begin
                    dec_fault = 1'b1;
                    dec_code  = CODE_ILLEGAL;
                end
            end
            default: begin
                dec_fault = 1'b1;
                dec_code  = CODE_ILLEGAL;
            end
        endcase
    end

    // Every output is set on the edge that enters the state it belongs to,
    // so pulses line up exactly with LINK / JUMP / FAULT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            instr_q    <= '0;
            pc_q       <= '0;
            target_q   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            link_write <= 1'b0;
            link_addr  <= '0;
            link_data  <= '0;
            pc_write   <= 1'b0;
            pc_next    <= '0;
        end else begin
            done       <= 1'b0;
            link_write <= 1'b0;
            pc_write   <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        instr_q    <= instruction;
                        pc_q       <= pc;
                        fault      <= 1'b0;
                        fault_code <= 2'b00;
                        busy       <= 1'b1;
                        state      <= DECODE;
                    end
                end

                DECODE: begin
                    // Latch the target now: a JALR with rd==rs must jump to
                    // the value rs held before the link write lands.
                    target_q <= dec_target;
                    if (dec_fault) begin
                        done       <= 1'b1;
                        fault      <= 1'b1;
                        fault_code <= dec_code;
                        state      <= FAULT;
                    end else if (dec_link) begin
                        link_write <= 1'b1;
                        link_addr  <= dec_laddr;
                        link_data  <= pc_q + LINK_INC;
                        state      <= LINK;
                    end else begin
                        pc_write <= 1'b1;
                        pc_next  <= dec_target;
                        done     <= 1'b1;
                        state    <= JUMP;
                    end
                end

                LINK: begin
                    pc_write <= 1'b1;
                    pc_next  <= target_q;
                    done     <= 1'b1;
                    state    <= JUMP;
                end

                JUMP, FAULT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jump_sequencer.sv
// ---------------------------------------------------------------------------
// tb_jump_sequencer
//
// Directed bench for jump_sequencer. Two instances share stimulus: the main
// one with default parameters, and a second one with LINK_OFFSET=8 and
// JALR_EN=0. Expected completions of the main instance are queued when an
// operation is launched and popped by a monitor when done pulses.
// ---------------------------------------------------------------------------
module tb_jump_sequencer;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [31:0]       instruction;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs_data;

    logic              busy, done, fault, link_write, pc_write;
    logic [1:0]        fault_code;
    logic [4:0]        link_addr;
    logic [DATA_W-1:0] link_data, pc_next;
    logic [2:0]        current_state;

    logic              b_busy, b_done, b_fault, b_link_write, b_pc_write;
    logic [1:0]        b_fault_code;
    logic [4:0]        b_link_addr;
    logic [DATA_W-1:0] b_link_data, b_pc_next;
    logic [2:0]        b_current_state;

    always #5 clk = ~clk;

    jump_sequencer #(
        .DATA_W(DATA_W), .LINK_OFFSET(4), .LINK_REG(31), .JALR_EN(1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .instruction(instruction),
        .pc(pc), .rs_data(rs_data), .busy(busy), .done(done), .fault(fault),
        .fault_code(fault_code), .link_write(link_write),
        .link_addr(link_addr), .link_data(link_data), .pc_write(pc_write),
        .pc_next(pc_next), .current_state(current_state)
    );

    jump_sequencer #(
        .DATA_W(DATA_W), .LINK_OFFSET(8), .LINK_REG(31), .JALR_EN(0)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start), .instruction(instruction),
        .pc(pc), .rs_data(rs_data), .busy(b_busy), .done(b_done),
        .fault(b_fault), .fault_code(b_fault_code),
        .link_write(b_link_write), .link_addr(b_link_addr),
        .link_data(b_link_data), .pc_write(b_pc_write),
        .pc_next(b_pc_next), .current_state(b_current_state)
    );

    typedef struct packed {
        logic        flt;
        logic [1:0]  code;
        logic        lnk;
        logic [4:0]  laddr;
        logic [31:0] ldata;
        logic [31:0] tgt;
    } exp_t;

    exp_t expq[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Completion monitor for the main instance.
    initial begin : monitor
        logic        seen_lnk;
        logic [4:0]  seen_addr;
        logic [31:0] seen_data;
        exp_t        e;
        seen_lnk  = 1'b0;
        seen_addr = '0;
        seen_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                seen_lnk = 1'b0;
            end else begin
                if (link_write) begin
                    seen_lnk  = 1'b1;
                    seen_addr = link_addr;
                    seen_data = link_data;
                end
                if (pc_write)
                    check("pc_write_only_with_done", {62'd0, done, fault}, 64'd2);
                if (done) begin
                    if (expq.size() == 0) begin
                        check("unexpected_done_queue", expq.size(), 1);
                    end else begin
                        e = expq.pop_front();
                        check("done_fault", fault, e.flt);
                        check("done_fault_code", fault_code, e.code);
                        check("done_pc_write", pc_write, !e.flt);
                        if (!e.flt) check("done_pc_next", pc_next, e.tgt);
                        check("link_write_seen", seen_lnk, e.lnk);
                        if (e.lnk) begin
                            check("link_addr", seen_addr, e.laddr);
                            check("link_data", seen_data, e.ldata);
                        end
                    end
                    seen_lnk = 1'b0;
                end
            end
        end
    end

    // Launch one operation and follow it to done. exp_cyc counts the IDLE
    // cycle in which start is sampled; 0 skips the latency comparison.
    task automatic run_op(input string tag, input logic [31:0] ins,
                          input logic [31:0] p, input logic [31:0] rs,
                          input bit flt, input logic [1:0] code,
                          input bit lnk, input logic [4:0] la,
                          input logic [31:0] ld, input logic [31:0] tgt,
                          input int exp_cyc, input bit poke);
        exp_t e;
        int   n;
        e.flt = flt; e.code = code; e.lnk = lnk;
        e.laddr = la; e.ldata = ld; e.tgt = tgt;
        expq.push_back(e);

        start = 1'b1; instruction = ins; pc = p; rs_data = 32'hBAD0_0001;
        @(posedge clk); #1;
        // Scramble the start-time inputs; a second start here must be ignored.
        start = poke; instruction = 32'hFFFF_FFFF; pc = 32'hFFFF_FFFF;
        rs_data = rs;
        @(negedge clk);
        n = 1;
        check({tag, "_decode_state"}, current_state, 3'd1);
        check({tag, "_decode_busy"}, busy, 1'b1);
        check({tag, "_fault_cleared"}, {fault, fault_code}, 3'd0);
        @(posedge clk); #1;
        start = 1'b0; rs_data = ~rs;
        @(negedge clk);
        n = 2;
        if (lnk) check({tag, "_link_state"}, current_state, 3'd2);
        while (!done && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
        if (exp_cyc > 0) check({tag, "_latency"}, n + 1, exp_cyc);
        check({tag, "_final_state"}, current_state, flt ? 3'd4 : 3'd3);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_idle_after"}, {current_state, busy, done}, 5'd0);
    endtask

    initial begin : stimulus
        int  d1, d2, cyc;
        bit  any_pw;
        logic [DATA_W-1:0] pc_before;

        reset = 1'b1; start = 1'b0; instruction = '0; pc = '0; rs_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_state", current_state, 3'd0);
        check("reset_ctrl", {busy, done, fault, fault_code, link_write, pc_write}, 7'd0);
        check("reset_link", {link_addr, link_data}, 37'd0);
        check("reset_pc_next", pc_next, 32'd0);

        run_op("j", 32'h0800_000C, 32'h0040_0010, 32'h0, 0, 2'b00,
               0, 5'd0, 32'h0, 32'h0000_0030, 3, 0);
        run_op("jal", 32'h0C00_0000, 32'h1000_0008, 32'h0, 0, 2'b00,
               1, 5'd31, 32'h1000_000C, 32'h1000_0000, 4, 0);
        run_op("jalr", 32'h0100_F809, 32'h0040_0000, 32'h0040_0100, 0, 2'b00,
               1, 5'd31, 32'h0040_0004, 32'h0040_0100, 4, 0);
        check("b_jalr_disabled_fault", {b_fault, b_fault_code}, 3'b101);
        run_op("jalr_misaligned", 32'h0100_F809, 32'h0040_0000, 32'h0040_0102,
               1, 2'b10, 0, 5'd0, 32'h0, 32'h0, 3, 0);
        run_op("addi", 32'h2000_0000, 32'h0040_0000, 32'h0, 1, 2'b01,
               0, 5'd0, 32'h0, 32'h0, 3, 0);
        check("fault_held_after_done", {fault, fault_code}, 3'b101);
        run_op("jr", 32'h0100_0008, 32'h0040_0020, 32'h0080_0040, 0, 2'b00,
               0, 5'd0, 32'h0, 32'h0080_0040, 3, 0);
        run_op("jalr_rd0", 32'h0100_0009, 32'h0040_0030, 32'h0000_0200, 0, 2'b00,
               0, 5'd0, 32'h0, 32'h0000_0200, 0, 0);
        run_op("busy_poke", 32'h0800_0010, 32'h0000_0100, 32'h0, 0, 2'b00,
               0, 5'd0, 32'h0, 32'h0000_0040, 3, 1);
        repeat (3) begin
            @(negedge clk);
            check("poke_not_queued_state", current_state, 3'd0);
        end
        check("poke_queue_empty", expq.size(), 0);

        // Back-to-back with start held high.
        begin
            exp_t e;
            e.flt = 0; e.code = 2'b00; e.lnk = 0; e.laddr = '0; e.ldata = '0;
            e.tgt = 32'h0000_0030;
            expq.push_back(e);
            expq.push_back(e);
        end
        start = 1'b1; instruction = 32'h0800_000C; pc = 32'h0040_0010; rs_data = '0;
        d1 = -1; d2 = -1; cyc = 0;
        while (d2 < 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done && d1 < 0) d1 = cyc;
            else if (d1 >= 0 && current_state == 3'd1) d2 = cyc;
        end
        check("b2b_gap_edges", d2 - d1, 2);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("b2b_second_done", {done, current_state}, 4'b1011);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_queue_empty", expq.size(), 0);

        run_op("jal_pc0", 32'h0C00_0000, 32'h0000_0000, 32'h0, 0, 2'b00,
               1, 5'd31, 32'h0000_0004, 32'h0000_0000, 4, 0);
        check("b_link_offset8", b_link_data, 32'h0000_0008);
        check("b_fault_cleared", {b_fault, b_fault_code}, 3'd0);
        run_op("jal_wrap", 32'h0C00_0000, 32'hFFFF_FFFC, 32'h0, 0, 2'b00,
               1, 5'd31, 32'h0000_0000, 32'hF000_0000, 4, 0);

        // Reset while a JAL sits in LINK.
        pc_before = pc_next;
        check("pre_reset_pc_next_nonzero", pc_before != 0, 1'b1);
        start = 1'b1; instruction = 32'h0C00_0000; pc = 32'h1000_0008;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_mid_in_link", current_state, 3'd2);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_mid_state", current_state, 3'd0);
        check("reset_mid_ctrl", {busy, done, fault, fault_code, link_write, pc_write}, 7'd0);
        check("reset_mid_data", {link_addr, link_data, pc_next}, 69'd0);
        reset = 1'b0;
        any_pw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            any_pw = any_pw | pc_write | link_write | done;
        end
        check("reset_mid_no_pending_write", any_pw, 1'b0);
        check("final_queue_empty", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

endmodule
